// File: rtl/semis_race_cmp_array.sv
// Multi-channel race comparator. Each channel is armed, waits for a precharge
// phase with both synced inputs low, then reports which input rose first.
// Resolved results are merged onto one valid/ready port by a round-robin arbiter.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   arm[CHANNELS]   per-channel start request, sampled only while IDLE
//   vip/vin         asynchronous race inputs, synchronised internally
//   busy            channel is not IDLE
//   res_valid/res_ready and res_ch/res_out/res_tie/res_timeout/res_lat
//                   result handshake and payload
module semis_race_cmp_array #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT     = 200
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         arm,
    input  logic [CHANNELS-1:0]         vip,
    input  logic [CHANNELS-1:0]         vin,
    output logic [CHANNELS-1:0]         busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(CHANNELS)-1:0] res_ch,
    output logic                        res_out,
    output logic                        res_tie,
    output logic                        res_timeout,
    output logic [CNT_W-1:0]            res_lat
);

    localparam int unsigned CH_W = $clog2(CHANNELS);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, PRECHG, RACE, DONE} state_t;

    logic [SYNC_STAGES-1:0] vip_pipe [CHANNELS];
    logic [SYNC_STAGES-1:0] vin_pipe [CHANNELS];
    logic [CHANNELS-1:0]    vip_s, vin_s;

    state_t              state     [CHANNELS];
    state_t              state_nxt [CHANNELS];
    logic [CNT_W-1:0]    cnt       [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt   [CHANNELS];
    logic [CNT_W-1:0]    lat       [CHANNELS];
    logic [CNT_W-1:0]    lat_nxt   [CHANNELS];
    logic [CHANNELS-1:0] r_out, r_tie, r_to;
    logic [CHANNELS-1:0] r_out_nxt, r_tie_nxt, r_to_nxt;

    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] gnt;
    logic [CH_W-1:0]     last_grant;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_vld;
    logic                load;

    // Input synchronisers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                vip_pipe[i] <= '0;
                vin_pipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                vip_pipe[i] <= {vip_pipe[i][SYNC_STAGES-2:0], vip[i]};
                vin_pipe[i] <= {vin_pipe[i][SYNC_STAGES-2:0], vin[i]};
            end
        end
    end

    always_comb begin
        vip_s = '0;
        vin_s = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            vip_s[i] = vip_pipe[i][SYNC_STAGES-1];
            vin_s[i] = vin_pipe[i][SYNC_STAGES-1];
        end
    end

    // Round-robin pick among DONE channels, starting after the last grant
    always_comb begin
        done      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            done[i] = (state[i] == DONE);
        end
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            int unsigned idx;
            idx = (32'(last_grant) + k) % CHANNELS;
            if (!grant_vld && done[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        load = grant_vld && (!res_valid || res_ready);
        gnt  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            gnt[i] = load && (grant_idx == CH_W'(i));
        end
    end

    // Per-channel next-state and result capture
    always_comb begin
        r_out_nxt = r_out;
        r_tie_nxt = r_tie;
        r_to_nxt  = r_to;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            lat_nxt[i]   = lat[i];
            case (state[i])
                IDLE: begin
                    if (arm[i]) begin
                        state_nxt[i] = PRECHG;
                        cnt_nxt[i]   = '0;
                    end
                end
                PRECHG: begin
                    cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(1);
                    if (!vip_s[i] && !vin_s[i]) begin
                        state_nxt[i] = RACE;
                    end else if (cnt[i] >= TMO) begin
                        state_nxt[i] = DONE;
                        r_out_nxt[i] = 1'b0;
                        r_tie_nxt[i] = 1'b0;
                        r_to_nxt[i]  = 1'b1;
                        lat_nxt[i]   = TMO;
                    end
                end
                RACE: begin
                    cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(1);
                    // An input event in the timeout cycle takes precedence
                    if (vip_s[i] || vin_s[i]) begin
                        state_nxt[i] = DONE;
                        r_out_nxt[i] = vip_s[i] & ~vin_s[i];
                        r_tie_nxt[i] = vip_s[i] & vin_s[i];
                        r_to_nxt[i]  = 1'b0;
                        lat_nxt[i]   = cnt[i];
                    end else if (cnt[i] >= TMO) begin
                        state_nxt[i] = DONE;
                        r_out_nxt[i] = 1'b0;
                        r_tie_nxt[i] = 1'b0;
                        r_to_nxt[i]  = 1'b1;
                        lat_nxt[i]   = TMO;
                    end
                end
                DONE: begin
                    if (gnt[i]) begin
                        state_nxt[i] = IDLE;
                    end
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                lat[i]   <= '0;
            end
            r_out <= '0;
            r_tie <= '0;
            r_to  <= '0;
            busy  <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                lat[i]   <= lat_nxt[i];
                busy[i]  <= (state_nxt[i] != IDLE);
            end
            r_out <= r_out_nxt;
            r_tie <= r_tie_nxt;
            r_to  <= r_to_nxt;
        end
    end

    // Result register: reloads on handshake for bubble-free back-to-back output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_out     <= 1'b0;
            res_tie     <= 1'b0;
            res_timeout <= 1'b0;
            res_lat     <= '0;
            last_grant  <= CH_W'(CHANNELS - 1);
        end else if (load) begin
            res_valid   <= 1'b1;
            res_ch      <= grant_idx;
            res_out     <= r_out[grant_idx];
            res_tie     <= r_tie[grant_idx];
            res_timeout <= r_to[grant_idx];
            res_lat     <= lat[grant_idx];
            last_grant  <= grant_idx;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_semis_race_cmp_array.sv
// Bench for semis_race_cmp_array with TIMEOUT=10.
module tb_semis_race_cmp_array;

    localparam int unsigned CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] arm, vip, vin, busy;
    logic          res_valid, res_ready, res_out, res_tie, res_timeout;
    logic [1:0]    res_ch;
    logic [7:0]    res_lat;

    typedef struct packed {
        logic [1:0] ch;
        logic       out;
        logic       tie;
        logic       to;
        logic [7:0] lat;
    } res_t;

    typedef struct {
        int   ch;
        int   delay;
        bit   raise;
        bit   p;
        bit   n;
        bit   pre_hi;
        res_t exp;
    } vec_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    semis_race_cmp_array #(
        .CHANNELS(4), .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .vip(vip), .vin(vin), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_out(res_out), .res_tie(res_tie), .res_timeout(res_timeout),
        .res_lat(res_lat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor plus stall-stability check
    res_t prev;
    bit   prev_stall = 1'b0;
    always @(negedge clk) begin
        res_t cur, e;
        cur = {res_ch, res_out, res_tie, res_timeout, res_lat};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(res_valid), 32'd1);
                check("stall_payload", 32'(cur), 32'(prev));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got ch=%0d lat=%0d expected none", res_ch, res_lat);
                end else begin
                    e = sb.pop_front();
                    check("res_ch", 32'(res_ch), 32'(e.ch));
                    check("res_out", 32'(res_out), 32'(e.out));
                    check("res_tie", 32'(res_tie), 32'(e.tie));
                    check("res_timeout", 32'(res_timeout), 32'(e.to));
                    check("res_lat", 32'(res_lat), 32'(e.lat));
                end
            end
            prev_stall = res_valid && !res_ready;
            prev       = cur;
        end
    end

    // Arm a channel for one cycle, then after 'delay' cycles optionally drive the inputs.
    // Expected latency for a raised input is delay+2.
    task automatic start_race(input int ch, input int delay, input bit raise, input bit p, input bit n);
        @(posedge clk); #1 arm[ch] = 1'b1;
        @(posedge clk); #1 arm[ch] = 1'b0;
        check("busy_after_arm", 32'(busy[ch]), 32'd1);
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1;
        end
        if (raise) begin
            vip[ch] = p;
            vin[ch] = n;
        end
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while (sb.size() != 0 && c < maxc) begin
            @(negedge clk); #1;
            c++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_valid(input int maxc);
        int c = 0;
        while (!res_valid && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("valid_seen", 32'(res_valid), 32'd1);
    endtask

    task automatic drop_inputs();
        @(posedge clk); #1;
        vip = '0;
        vin = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0, 2, 1, 1, 0, 0, '{2'd0, 1'b1, 1'b0, 1'b0, 8'd4}};
        vecs[1] = '{1, 1, 1, 1, 1, 0, '{2'd1, 1'b0, 1'b1, 1'b0, 8'd3}};
        vecs[2] = '{2, 0, 0, 0, 0, 1, '{2'd2, 1'b0, 1'b0, 1'b1, 8'd10}};
        vecs[3] = '{2, 3, 1, 0, 1, 0, '{2'd2, 1'b0, 1'b0, 1'b0, 8'd5}};
        vecs[4] = '{3, 0, 1, 1, 0, 0, '{2'd3, 1'b1, 1'b0, 1'b0, 8'd2}};
        vecs[5] = '{3, 8, 1, 1, 0, 0, '{2'd3, 1'b1, 1'b0, 1'b0, 8'd10}};
        vecs[6] = '{0, 9, 1, 1, 0, 0, '{2'd0, 1'b0, 1'b0, 1'b1, 8'd10}};
        vecs[7] = '{1, 0, 0, 0, 0, 0, '{2'd1, 1'b0, 1'b0, 1'b1, 8'd10}};
        vecs[8] = '{2, 5, 1, 0, 1, 0, '{2'd2, 1'b0, 1'b0, 1'b0, 8'd7}};

        rst = 1'b1; arm = '0; vip = '0; vin = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_payload", 32'({res_ch, res_out, res_tie, res_timeout, res_lat}), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single-channel races from the vector table
        foreach (vecs[i]) begin
            if (vecs[i].pre_hi) begin
                vin[vecs[i].ch] = 1'b1;
                repeat (4) @(posedge clk);
                #1;
            end
            sb.push_back(vecs[i].exp);
            start_race(vecs[i].ch, vecs[i].delay, vecs[i].raise, vecs[i].p, vecs[i].n);
            wait_drain(80);
            check("busy_after_grant", 32'(busy[vecs[i].ch]), 32'd0);
            drop_inputs();
        end

        // Arm pulses to a busy channel are ignored
        res_ready = 1'b0;
        sb.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 8'd3});
        start_race(1, 1, 1, 1, 0);
        wait_valid(40);
        @(posedge clk); #1 arm[0] = 1'b1;
        @(posedge clk); #1;
        check("busy_ch0", 32'(busy[0]), 32'd1);
        repeat (2) @(posedge clk);
        #1 vip[0] = 1'b1;
        sb.push_back('{2'd0, 1'b1, 1'b0, 1'b0, 8'd4});
        repeat (8) @(posedge clk);
        #1;
        check("busy_ch0_done", 32'(busy[0]), 32'd1);
        arm[0] = 1'b0;
        res_ready = 1'b1;
        wait_drain(40);
        drop_inputs();
        repeat (30) @(posedge clk);
        #1;
        check("no_extra_busy", 32'(busy), 32'd0);
        check("no_extra_valid", 32'(res_valid), 32'd0);

        // Reset with a pending result and ch3 mid-race
        res_ready = 1'b0;
        start_race(1, 1, 1, 1, 0);
        wait_valid(40);
        start_race(3, 2, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_valid", 32'(res_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_payload", 32'({res_ch, res_out, res_tie, res_timeout, res_lat}), 32'd0);
        vip = '0;
        vin = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        res_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("stale_valid", 32'(res_valid), 32'd0);
        check("stale_busy", 32'(busy), 32'd0);

        // All four resolve together under backpressure: order 0..3, no bubbles
        res_ready = 1'b0;
        @(posedge clk); #1 arm = 4'hF;
        @(posedge clk); #1 arm = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        vip = 4'b1101;
        vin = 4'b0110;
        sb.push_back('{2'd0, 1'b1, 1'b0, 1'b0, 8'd4});
        sb.push_back('{2'd1, 1'b0, 1'b0, 1'b0, 8'd4});
        sb.push_back('{2'd2, 1'b0, 1'b1, 1'b0, 8'd4});
        sb.push_back('{2'd3, 1'b1, 1'b0, 1'b0, 8'd4});
        wait_valid(40);
        repeat (5) @(negedge clk);
        check("stall_ch", 32'(res_ch), 32'd0);
        @(posedge clk); #1 res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_valid", 32'(res_valid), 32'd1);
        end
        #1;
        wait_drain(20);
        drop_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
